// File: rtl/midori_rc_sequencer.sv
// Midori round-constant sequencer: steps through beta0..beta(N_RC-1) forward or
// reversed and presents each constant expanded to cell LSBs on share 0.
module midori_rc_sequencer #(
   parameter int N_RC   = 15,
   parameter int CELL_W = 4,
   parameter int SHARES = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         dec,
   input  logic                         adv,
   output logic                         busy,
   output logic                         rc_valid,
   output logic                         last,
   output logic                         done,
   output logic [4:0]                   round_idx,
   output logic [15:0]                  rc_raw,
   output logic [16*CELL_W-1:0]         rc_cell,
   output logic [SHARES*16*CELL_W-1:0]  rc_sh
);

   if (N_RC < 1 || N_RC > 19) begin : g_bad_n_rc
      $error("midori_rc_sequencer: N_RC must be in 1..19");
   end
   if (CELL_W != 4 && CELL_W != 8) begin : g_bad_cell_w
      $error("midori_rc_sequencer: CELL_W must be 4 or 8");
   end
   if (SHARES < 2) begin : g_bad_shares
      $error("midori_rc_sequencer: SHARES must be at least 2");
   end

   localparam logic [4:0] LAST_IDX = 5'(N_RC - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      state, state_n;
   logic        dec_q, dec_n;
   logic [4:0]  idx_n;
   logic        busy_n, valid_n, last_n, done_n;
   logic [15:0] raw_n;

   function automatic logic [15:0] beta(input logic [4:0] i);
      case (i)
         5'd0:    beta = 16'h15B3;
         5'd1:    beta = 16'h78C0;
         5'd2:    beta = 16'hA435;
         5'd3:    beta = 16'h6213;
         5'd4:    beta = 16'h104F;
         5'd5:    beta = 16'hD170;
         5'd6:    beta = 16'h0266;
         5'd7:    beta = 16'h0BCC;
         5'd8:    beta = 16'h9481;
         5'd9:    beta = 16'h40B8;
         5'd10:   beta = 16'h7197;
         5'd11:   beta = 16'h228E;
         5'd12:   beta = 16'h5130;
         5'd13:   beta = 16'hF8CA;
         5'd14:   beta = 16'hDF90;
         5'd15:   beta = 16'h7C81;
         5'd16:   beta = 16'h1C24;
         5'd17:   beta = 16'h23B4;
         5'd18:   beta = 16'h62A8;
         default: beta = '0;
      endcase
   endfunction

   function automatic logic is_last(input logic d, input logic [4:0] i);
      return d ? (i == 5'd0) : (i == LAST_IDX);
   endfunction

   always_comb begin
      state_n = state;
      dec_n   = dec_q;
      idx_n   = round_idx;
      busy_n  = 1'b0;
      valid_n = 1'b0;
      last_n  = 1'b0;
      done_n  = 1'b0;
      raw_n   = '0;
      case (state)
         S_IDLE: begin
            if (start) begin
               dec_n   = dec;
               idx_n   = dec ? LAST_IDX : 5'd0;
               state_n = S_RUN;
               busy_n  = 1'b1;
               valid_n = 1'b1;
               last_n  = is_last(dec, idx_n);
               raw_n   = beta(idx_n);
            end
         end
         S_RUN: begin
            busy_n = 1'b1;
            if (adv && last) begin
               state_n = S_DONE;
               done_n  = 1'b1;
            end else if (adv) begin
               // last=0 guarantees the step stays inside 0..N_RC-1
               idx_n   = dec_q ? round_idx - 5'd1 : round_idx + 5'd1;
               valid_n = 1'b1;
               last_n  = is_last(dec_q, idx_n);
               raw_n   = beta(idx_n);
            end else begin
               valid_n = 1'b1;
               last_n  = last;
               raw_n   = rc_raw;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         dec_q     <= 1'b0;
         round_idx <= '0;
         busy      <= 1'b0;
         rc_valid  <= 1'b0;
         last      <= 1'b0;
         done      <= 1'b0;
         rc_raw    <= '0;
      end else begin
         state     <= state_n;
         dec_q     <= dec_n;
         round_idx <= idx_n;
         busy      <= busy_n;
         rc_valid  <= valid_n;
         last      <= last_n;
         done      <= done_n;
         rc_raw    <= raw_n;
      end
   end

   // Pure wiring of the registered constant; bit 15 maps to cell 0 at the top.
   for (genvar k = 0; k < 16; k++) begin : g_cell
      assign rc_cell[(16-k)*CELL_W-1 -: CELL_W] = {{(CELL_W-1){1'b0}}, rc_raw[15-k]};
   end

   assign rc_sh[16*CELL_W-1:0]                 = rc_cell;
   assign rc_sh[SHARES*16*CELL_W-1:16*CELL_W]  = '0;

endmodule
